// File: rtl/zmips_ex_mem_buf.sv
// Execute-to-memory pipeline buffer with BEQ/BNE resolution, 2-entry skid storage.
// Latency: 1 cycle from accepted input to mem_valid; br_taken pulses 1 cycle after the accept.
// Backpressure: ex_ready is decoded from registered occupancy only, never from mem_ready.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   flush                  synchronous flush, drops held and same-cycle incoming entries
//   ex_valid / ex_ready    upstream handshake; alu_*, ex_* carry the entry payload
//   mem_valid / mem_ready  downstream handshake; mem_* carry the head entry
//   br_taken, br_pc        registered branch-taken pulse and its target PC
module zmips_ex_mem_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [1:0]        ex_br_type,
  input  logic [DATA_W-1:0] ex_br_target,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_y,
  output logic              mem_cout,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_we,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_pc
);

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              cout;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] st_data;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] BR_BEQ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;

  state_t            state_q, state_d;
  ent_t              main_q, main_d;
  ent_t              skid_q, skid_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_pc_q, br_pc_d;

  ent_t in_ent;
  logic in_xfer;
  logic out_xfer;
  logic br_hit;

  // Handshake outputs decode flops only, so no mem_ready -> ex_ready path exists.
  assign ex_ready  = (state_q != S_FULL);
  assign mem_valid = (state_q != S_EMPTY);

  assign in_xfer  = ex_valid & ex_ready;
  assign out_xfer = mem_valid & mem_ready;

  // Reserved type 11 falls through both terms and resolves as not taken.
  assign br_hit = ((ex_br_type == BR_BEQ) &  alu_zero) |
                  ((ex_br_type == BR_BNE) & ~alu_zero);

  always_comb begin
    in_ent.y       = alu_y;
    in_ent.cout    = alu_cout;
    in_ent.rd      = ex_rd;
    in_ent.reg_we  = ex_reg_we;
    in_ent.mem_rd  = ex_mem_rd;
    in_ent.mem_wr  = ex_mem_wr;
    in_ent.st_data = ex_st_data;
  end

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    br_taken_d = 1'b0;
    br_pc_d    = br_pc_q;

    if (flush) begin
      // Same-cycle output is treated as consumed; same-cycle input is dropped
      // and cannot fire a branch.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_d  = in_ent;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_ent;
          end else if (in_xfer) begin
            state_d = S_FULL;
            skid_d  = in_ent;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // ex_ready is low here, so only a drain can happen.
          if (out_xfer) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase

      if (in_xfer && br_hit) begin
        br_taken_d = 1'b1;
        br_pc_d    = ex_br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
    end
  end

  assign mem_y       = main_q.y;
  assign mem_cout    = main_q.cout;
  assign mem_rd      = main_q.rd;
  assign mem_reg_we  = main_q.reg_we;
  assign mem_mem_rd  = main_q.mem_rd;
  assign mem_mem_wr  = main_q.mem_wr;
  assign mem_st_data = main_q.st_data;
  assign br_taken    = br_taken_q;
  assign br_pc       = br_pc_q;

endmodule

// File: tb/tb_zmips_ex_mem_buf.sv
module tb_zmips_ex_mem_buf;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int PW     = 2 * DATA_W + REG_AW + 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              alu_cout;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_we;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic [DATA_W-1:0] ex_st_data;
  logic [1:0]        ex_br_type;
  logic [DATA_W-1:0] ex_br_target;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_y;
  logic              mem_cout;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_we;
  logic              mem_mem_rd;
  logic              mem_mem_wr;
  logic [DATA_W-1:0] mem_st_data;
  logic              br_taken;
  logic [DATA_W-1:0] br_pc;

  int errors = 0;
  int checks = 0;

  // Scoreboard state: expected payload queue plus expected branch outputs.
  logic [PW-1:0]     exp_q[$];
  logic              exp_br;
  logic [DATA_W-1:0] exp_pc;

  zmips_ex_mem_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_st_data(ex_st_data),
    .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_y(mem_y), .mem_cout(mem_cout), .mem_rd(mem_rd),
    .mem_reg_we(mem_reg_we), .mem_mem_rd(mem_mem_rd),
    .mem_mem_wr(mem_mem_wr), .mem_st_data(mem_st_data),
    .br_taken(br_taken), .br_pc(br_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] in_payload();
    return {alu_y, alu_cout, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_st_data};
  endfunction

  // Monitor: at each falling edge compare outputs against the scoreboard,
  // then advance the model for the coming rising edge (inputs are stable).
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_br = 1'b0;
      exp_pc = '0;
      chk("rst_mem_valid", PW'(mem_valid), PW'(1'b0));
      chk("rst_ex_ready",  PW'(ex_ready),  PW'(1'b1));
      chk("rst_br_taken",  PW'(br_taken),  PW'(1'b0));
      chk("rst_br_pc",     PW'(br_pc),     PW'(0));
      chk("rst_mem_y",     PW'(mem_y),     PW'(0));
    end else begin
      logic inx, outx;
      chk("mem_valid", PW'(mem_valid), PW'(exp_q.size() > 0));
      chk("ex_ready",  PW'(ex_ready),  PW'(exp_q.size() < 2));
      chk("br_taken",  PW'(br_taken),  PW'(exp_br));
      chk("br_pc",     PW'(br_pc),     PW'(exp_pc));
      if (exp_q.size() > 0)
        chk("payload", {mem_y, mem_cout, mem_rd, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_st_data},
            exp_q[0]);
      outx = (exp_q.size() > 0) && mem_ready;
      inx  = ex_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
        exp_br = 1'b0;
      end else begin
        if (outx) void'(exp_q.pop_front());
        if (inx) exp_q.push_back(in_payload());
        exp_br = inx && (((ex_br_type == 2'b01) && alu_zero) || ((ex_br_type == 2'b10) && !alu_zero));
        if (exp_br) exp_pc = ex_br_target;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload side fields are derived from y so every field gets exercised.
  task automatic put(input logic v, input logic [DATA_W-1:0] y, input logic [1:0] bt,
                     input logic z, input logic [DATA_W-1:0] tgt);
    ex_valid     = v;
    alu_y        = y;
    alu_cout     = y[2];
    ex_rd        = y[4:0] ^ 5'h15;
    ex_reg_we    = (bt == 2'b00);
    ex_mem_rd    = y[0];
    ex_mem_wr    = y[1];
    ex_st_data   = ~y;
    ex_br_type   = bt;
    alu_zero     = z;
    ex_br_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    put(1'b0, 0, 2'b00, 1'b0, 0);
    exp_br = 1'b0; exp_pc = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("d_reset_valid", PW'(mem_valid), PW'(1'b0));
    chk("d_reset_ready", PW'(ex_ready),  PW'(1'b1));

    // Back-to-back stream with the sink always ready.
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(1'b1, i, 2'b00, 1'b0, 0);
      tick();
      chk("d_stream_y", PW'(mem_y), PW'(i));
      chk("d_stream_rdy", PW'(ex_ready), PW'(1'b1));
    end
    put(1'b0, 0, 2'b00, 1'b0, 0);
    tick();
    chk("d_stream_idle", PW'(mem_valid), PW'(1'b0));

    // Stall fills both slots, then drain in order.
    mem_ready = 1'b0;
    put(1'b1, 32'hA, 2'b00, 1'b0, 0); tick();
    put(1'b1, 32'hB, 2'b00, 1'b0, 0); tick();
    put(1'b0, 0, 2'b00, 1'b0, 0);
    chk("d_full_ready", PW'(ex_ready), PW'(1'b0));
    chk("d_full_head",  PW'(mem_y),    PW'(32'hA));
    tick();
    chk("d_full_hold",  PW'(mem_y),    PW'(32'hA));
    mem_ready = 1'b1;
    tick();
    chk("d_drain_y",    PW'(mem_y),    PW'(32'hB));
    chk("d_drain_rdy",  PW'(ex_ready), PW'(1'b1));
    tick();
    chk("d_drain_empty", PW'(mem_valid), PW'(1'b0));

    // Branch resolution.
    put(1'b1, 0, 2'b01, 1'b1, 32'h0040_0010); tick();
    put(1'b0, 0, 2'b00, 1'b0, 0);
    chk("d_beq_taken", PW'(br_taken), PW'(1'b1));
    chk("d_beq_pc",    PW'(br_pc),    PW'(32'h0040_0010));
    tick();
    chk("d_beq_pulse", PW'(br_taken), PW'(1'b0));
    chk("d_beq_hold",  PW'(br_pc),    PW'(32'h0040_0010));
    put(1'b1, 0, 2'b10, 1'b1, 32'h0000_0200); tick();
    chk("d_bne_nt",    PW'(br_taken), PW'(1'b0));
    put(1'b1, 0, 2'b11, 1'b1, 32'h0000_0300); tick();
    chk("d_rsv_nt",    PW'(br_taken), PW'(1'b0));
    put(1'b1, 5, 2'b10, 1'b0, 32'h0000_0100); tick();
    put(1'b0, 0, 2'b00, 1'b0, 0);
    chk("d_bne_taken", PW'(br_taken), PW'(1'b1));
    chk("d_bne_pc",    PW'(br_pc),    PW'(32'h0000_0100));
    tick(); tick();

    // Flush while full, with a taken BEQ presented the same cycle.
    mem_ready = 1'b0;
    put(1'b1, 32'h11, 2'b00, 1'b0, 0); tick();
    put(1'b1, 32'h12, 2'b00, 1'b0, 0); tick();
    put(1'b1, 32'h13, 2'b01, 1'b1, 32'h0000_0400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(1'b0, 0, 2'b00, 1'b0, 0);
    chk("d_flush_valid", PW'(mem_valid), PW'(1'b0));
    chk("d_flush_ready", PW'(ex_ready),  PW'(1'b1));
    chk("d_flush_br",    PW'(br_taken),  PW'(1'b0));
    chk("d_flush_pc",    PW'(br_pc),     PW'(32'h0000_0100));
    tick();

    // Asynchronous reset while full, away from any clock edge.
    put(1'b1, 32'h21, 2'b00, 1'b0, 0); tick();
    put(1'b1, 32'h22, 2'b01, 1'b1, 32'h0000_0500); tick();
    put(1'b0, 0, 2'b00, 1'b0, 0);
    chk("d_pre_arst_full", PW'(ex_ready), PW'(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("d_arst_valid", PW'(mem_valid), PW'(1'b0));
    chk("d_arst_ready", PW'(ex_ready),  PW'(1'b1));
    chk("d_arst_br",    PW'(br_taken),  PW'(1'b0));
    chk("d_arst_y",     PW'(mem_y),     PW'(0));
    chk("d_arst_pc",    PW'(br_pc),     PW'(0));
    tick(); tick();
    rst_n = 1'b1;

    // Random stress against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      put(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom);
      mem_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end

    put(1'b0, 0, 2'b00, 1'b0, 0);
    flush = 1'b0;
    mem_ready = 1'b1;
    repeat (4) tick();
    chk("d_final_empty", PW'(mem_valid), PW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
